// File: rtl/id_stage.sv
// id_stage: instruction-decode stage feeding the ID/EX pipeline register.
// Holds the 32 x XLEN integer register file, decodes the IF/ID instruction
// into the control bundle and immediate, and reads rs1/rs2 with optional
// write-back bypass. It also raises the load-use stall.
// Optional feature macro: ID_STALL_COUNT_EN adds a saturating stall counter
// on output stall_count_out.
module id_stage #(
    parameter int          XLEN      = 32,
    parameter int          CNT_W     = 16,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            id_ex_mem_read,
    input  logic [4:0]      id_ex_rd,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out,
    output logic            reg_write_out,
    output logic            alu_src_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            mem_to_reg_out,
    output logic            branch_out,
    output logic [1:0]      alu_op_out,
    output logic            illegal_out,
    output logic            stall_out
`ifdef ID_STALL_COUNT_EN
    ,
    output logic [CNT_W-1:0] stall_count_out
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The immediate builders below assume at least a 13-bit datapath.
    if (XLEN < 13) begin : g_xlen_chk
        $error("id_stage: XLEN must be at least 13");
    end
    if (CNT_W < 1) begin : g_cnt_chk
        $error("id_stage: CNT_W must be at least 1");
    end

    logic [XLEN-1:0] regs_q [32];

    logic [6:0] opcode;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic       wb_en;

    // Decoded control before gating by instr_valid / reset.
    logic       dec_legal;
    logic       dec_uses_rs2;
    logic       dec_no_rd;
    logic       dec_reg_write;
    logic       dec_alu_src;
    logic [1:0] dec_alu_op;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_mem_to_reg;
    logic       dec_branch;
    logic [XLEN-1:0] dec_imm;
    logic       active;
    logic       hazard_rs1;
    logic       hazard_rs2;

    assign opcode  = instr_in[6:0];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];
    assign wb_en   = wb_reg_write && (wb_rd != 5'd0);
    assign active  = reset_n && instr_valid;

    // Register file: cleared asynchronously, written on the rising edge; x0 is never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Opcode decode into the control bundle, immediate and register usage.
    always_comb begin
        dec_legal      = 1'b0;
        dec_uses_rs2   = 1'b0;
        dec_no_rd      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = 2'b00;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_imm        = '0;
        case (opcode)
            OP_R: begin
                dec_legal     = 1'b1;
                dec_uses_rs2  = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
            end
            OP_IALU: begin
                dec_legal     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 2'b11;
                dec_imm       = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
            end
            OP_LOAD: begin
                dec_legal      = 1'b1;
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_imm        = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
            end
            OP_STORE: begin
                dec_legal     = 1'b1;
                dec_uses_rs2  = 1'b1;
                dec_no_rd     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_imm       = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            end
            OP_BRANCH: begin
                dec_legal    = 1'b1;
                dec_uses_rs2 = 1'b1;
                dec_no_rd    = 1'b1;
                dec_alu_op   = 2'b01;
                dec_branch   = 1'b1;
                dec_imm      = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                                instr_in[30:25], instr_in[11:8], 1'b0};
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Output drive: fields pass through; controls are squashed for bubbles and during reset.
    always_comb begin
        pc_out         = pc_in;
        rs1_out        = rs1_idx;
        rs2_out        = rs2_idx;
        rd_out         = dec_no_rd ? 5'd0 : instr_in[11:7];
        funct3_out     = instr_in[14:12];
        funct7_out     = instr_in[31:25];
        imm_out        = dec_imm;
        reg_write_out  = active && dec_reg_write;
        alu_src_out    = active && dec_alu_src;
        alu_op_out     = active ? dec_alu_op : 2'b00;
        mem_read_out   = active && dec_mem_read;
        mem_write_out  = active && dec_mem_write;
        mem_to_reg_out = active && dec_mem_to_reg;
        branch_out     = active && dec_branch;
        illegal_out    = active && !dec_legal;
    end

    // Register reads with write-first bypass; x0 and reset both read as zero.
    always_comb begin
        rs1_data_out = '0;
        rs2_data_out = '0;
        if (reset_n) begin
            if (rs1_idx != 5'd0) begin
                if ((WB_BYPASS != 0) && wb_en && (wb_rd == rs1_idx)) begin
                    rs1_data_out = wb_data;
                end else begin
                    rs1_data_out = regs_q[rs1_idx];
                end
            end
            if (rs2_idx != 5'd0) begin
                if ((WB_BYPASS != 0) && wb_en && (wb_rd == rs2_idx)) begin
                    rs2_data_out = wb_data;
                end else begin
                    rs2_data_out = regs_q[rs2_idx];
                end
            end
        end
    end

    // Load-use hazard: the load in EX targets a register this instruction actually reads.
    always_comb begin
        hazard_rs1 = dec_legal && (id_ex_rd == rs1_idx);
        hazard_rs2 = dec_uses_rs2 && (id_ex_rd == rs2_idx);
        stall_out  = active && id_ex_mem_read && (id_ex_rd != 5'd0) && (hazard_rs1 || hazard_rs2);
    end

`ifdef ID_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count of stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, table-driven bench for id_stage (default parameters).
module tb_id_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic            clk;
    logic            reset_n;
    logic            instr_valid;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            id_ex_mem_read;
    logic [4:0]      id_ex_rd;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] rs1_data_out;
    logic [XLEN-1:0] rs2_data_out;
    logic [XLEN-1:0] imm_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;
    logic            reg_write_out;
    logic            alu_src_out;
    logic            mem_read_out;
    logic            mem_write_out;
    logic            mem_to_reg_out;
    logic            branch_out;
    logic [1:0]      alu_op_out;
    logic            illegal_out;
    logic            stall_out;
`ifdef ID_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_count_out;
`endif

    int checks;
    int failures;

    id_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .WB_BYPASS(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr_valid    (instr_valid),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .pc_out         (pc_out),
        .rs1_data_out   (rs1_data_out),
        .rs2_data_out   (rs2_data_out),
        .imm_out        (imm_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .funct3_out     (funct3_out),
        .funct7_out     (funct7_out),
        .reg_write_out  (reg_write_out),
        .alu_src_out    (alu_src_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .branch_out     (branch_out),
        .alu_op_out     (alu_op_out),
        .illegal_out    (illegal_out),
        .stall_out      (stall_out)
`ifdef ID_STALL_COUNT_EN
        ,
        .stall_count_out(stall_count_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {reg_write, alu_src, alu_op[1:0], mem_read, mem_write, mem_to_reg, branch}
    function automatic logic [7:0] ctrl_bundle();
        return {reg_write_out, alu_src_out, alu_op_out, mem_read_out,
                mem_write_out, mem_to_reg_out, branch_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic        wbw;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        exmr;
        logic [4:0]  exrd;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic [7:0]  e_ctrl;
        logic        e_ill;
        logic        e_stall;
    } vec_t;

    vec_t vecs [16];

    task automatic drive(input logic v, input logic [31:0] ins, input logic wbw,
                         input logic [4:0] wrd, input logic [31:0] wdata,
                         input logic exmr, input logic [4:0] exrd);
        instr_valid    = v;
        instr_in       = ins;
        wb_reg_write   = wbw;
        wb_rd          = wrd;
        wb_data        = wdata;
        id_ex_mem_read = exmr;
        id_ex_rd       = exrd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pc_in    = 32'h0000_1000;
        reset_n  = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        //                 valid instr          wbw wrd    wdata          exmr exrd   rs1           rs2           imm           rd     ctrl   ill   stall
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        5'd0,  8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        5'd0,  8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0000_00AA,32'h0,        32'h0,        5'd7,  8'hA0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFF1_8213, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0,  32'h0000_1234,32'h0,        32'hFFFF_FFFF,5'd4,  8'hF0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0020_A423, 1'b0, 5'd0, 32'h0,         1'b1, 5'd2,  32'h0,        32'h0,        32'h0000_0008,5'd0,  8'h44, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h0020_A423, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0,  32'h0,        32'h0,        32'h0000_0008,5'd0,  8'h44, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h0030_0433, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 5'd0,  32'h0,        32'h0000_1234,32'h0,        5'd8,  8'hA0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h0030_0433, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,        32'h0000_1234,32'h0,        5'd8,  8'hA0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hFE20_8EE3, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,        32'h0,        32'hFFFF_FFFC,5'd0,  8'h11, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_006F, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0,  32'h0,        32'h0,        32'h0,        5'd0,  8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h00C2_A483, 1'b0, 5'd0, 32'h0,         1'b1, 5'd12, 32'h0000_00AA,32'h0,        32'h0000_000C,5'd9,  8'hCA, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h00C2_A483, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5,  32'h0000_00AA,32'h0,        32'h0000_000C,5'd9,  8'hCA, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'hFE62_AC23, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6,  32'h0000_00AA,32'h0,        32'hFFFF_FFF8,5'd0,  8'h44, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0062_83B3, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5,  32'h0000_00AA,32'h0,        32'h0,        5'd7,  8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'h0030_0433, 1'b1, 5'd3, 32'h0000_5678, 1'b0, 5'd0,  32'h0,        32'h0000_5678,32'h0,        5'd8,  8'hA0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 32'h0030_0433, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,        32'h0000_5678,32'h0,        5'd8,  8'hA0, 1'b0, 1'b0};

        // Reset state, including a stalling load-use pattern that reset must squash.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        #1;
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_ctrl", {24'd0, ctrl_bundle()}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_out}, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        reset_n = 1'b1;
`ifdef ID_STALL_COUNT_EN
        #1;
        chk("cnt_reset", {16'd0, stall_count_out}, 32'd0);
`endif

        // Every register reads zero after reset.
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            drive(1'b1, {7'd0, 5'd0, r[4:0], 3'd0, 5'd1, 7'b0110011}, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            #1;
            chk($sformatf("rst_x%0d", r), rs1_data_out, 32'h0);
        end
        chk("rst_pc", pc_out, 32'h0000_1000);

        // Table-driven decode / read / hazard vectors (writes commit after each check).
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].instr, vecs[i].wbw, vecs[i].wrd, vecs[i].wdata,
                  vecs[i].exmr, vecs[i].exrd);
            #1;
            chk($sformatf("v%0d_rs1", i), rs1_data_out, vecs[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), rs2_data_out, vecs[i].e_rs2);
            chk($sformatf("v%0d_imm", i), imm_out, vecs[i].e_imm);
            chk($sformatf("v%0d_rd", i), {27'd0, rd_out}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_ctrl", i), {24'd0, ctrl_bundle()}, {24'd0, vecs[i].e_ctrl});
            chk($sformatf("v%0d_ill", i), {31'd0, illegal_out}, {31'd0, vecs[i].e_ill});
            chk($sformatf("v%0d_stall", i), {31'd0, stall_out}, {31'd0, vecs[i].e_stall});
        end
        chk("fields_rs1", {27'd0, rs1_out}, 32'd0);
        chk("fields_rs2", {27'd0, rs2_out}, 32'd3);

        // Write-back during a stall is bypassed, and the re-decode sees it from the array.
        @(negedge clk);
        drive(1'b1, 32'h0004_8533, 1'b1, 5'd9, 32'h0000_0077, 1'b1, 5'd9);
        #1;
        chk("stallwb_stall", {31'd0, stall_out}, 32'd1);
        chk("stallwb_rs1", rs1_data_out, 32'h0000_0077);
        chk("stallwb_rd", {27'd0, rd_out}, 32'd10);
        @(negedge clk);
        drive(1'b1, 32'h0004_8533, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
        #1;
        chk("redecode_stall", {31'd0, stall_out}, 32'd0);
        chk("redecode_rs1", rs1_data_out, 32'h0000_0077);

        // Reset asserted during a write: the write is lost and outputs go quiet at once.
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 1'b1, 5'd5, 32'h0000_0099, 1'b1, 5'd5);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_rs1", rs1_data_out, 32'h0);
        chk("midrst_ctrl", {24'd0, ctrl_bundle()}, 32'd0);
        chk("midrst_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        reset_n = 1'b1;
        #1;
        chk("postrst_x5", rs1_data_out, 32'h0);
        chk("postrst_ctrl", {24'd0, ctrl_bundle()}, 32'h0000_00A0);

`ifdef ID_STALL_COUNT_EN
        // Three stalling cycles after a fresh reset give a count of three.
        chk("cnt_after_rst", {16'd0, stall_count_out}, 32'd0);
        drive(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        chk("cnt_three", {16'd0, stall_count_out}, 32'd3);
        @(negedge clk);
        #1;
        chk("cnt_hold", {16'd0, stall_count_out}, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
